// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory request/response handshake
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC/fetch stage; optional retire/redirect counters under PC_FETCH_COUNTERS_EN
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pc_source_i,
    input  logic [XLEN-1:0]   branch_offset_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic              retire_i,
    input  logic              stall_i,
    pc_fetch_unit_if.master   imem,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic              inst_valid_o,
    output logic              misaligned_o,
    output logic [XLEN-1:0]   misaligned_addr_o
`ifdef PC_FETCH_COUNTERS_EN
    ,
    output logic [31:0]       retired_count_o,
    output logic [31:0]       redirect_count_o
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_TRAP  = 2'd3
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_valid_q;
    logic            misaligned_q;
    logic [XLEN-1:0] misaligned_addr_q;

    logic [XLEN-1:0] next_pc_d;
    logic            retire_ok;
    logic            target_aligned;
    logic            is_redirect;

    always_comb begin
        next_pc_d   = pc_q + XLEN'(4);
        is_redirect = 1'b0;
        case (pc_source_i)
            2'd1: begin
                next_pc_d   = pc_q + branch_offset_i;
                is_redirect = 1'b1;
            end
            2'd2: begin
                next_pc_d   = alu_result_i & ~XLEN'(1);
                is_redirect = 1'b1;
            end
            default: begin
                next_pc_d   = pc_q + XLEN'(4);
                is_redirect = 1'b0;
            end
        endcase
    end

    assign retire_ok      = (state_q == S_ISSUE) && retire_i && !stall_i;
    assign target_aligned = (next_pc_d[1:0] == 2'b00);

    // Request is combinational so it rises in the first cycle out of reset.
    assign imem.imem_req  = (state_q == S_FETCH) && !stall_i;
    assign imem.imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_FETCH;
            pc_q              <= RESET_VECTOR;
            inst_q            <= '0;
            inst_pc_q         <= '0;
            inst_valid_q      <= 1'b0;
            misaligned_q      <= 1'b0;
            misaligned_addr_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem.imem_req && imem.imem_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        inst_q       <= imem.imem_rdata;
                        inst_pc_q    <= pc_q;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (retire_ok) begin
                        inst_valid_q <= 1'b0;
                        if (target_aligned) begin
                            pc_q    <= next_pc_d;
                            state_q <= S_FETCH;
                        end else begin
                            misaligned_q      <= 1'b1;
                            misaligned_addr_q <= next_pc_d;
                            state_q           <= S_TRAP;
                        end
                    end
                end
                default: begin
                    // Terminal until reset.
                    state_q      <= S_TRAP;
                    inst_valid_q <= 1'b0;
                    misaligned_q <= 1'b1;
                end
            endcase
        end
    end

    assign inst_o            = inst_q;
    assign inst_pc_o         = inst_pc_q;
    assign inst_valid_o      = inst_valid_q;
    assign misaligned_o      = misaligned_q;
    assign misaligned_addr_o = misaligned_addr_q;

`ifdef PC_FETCH_COUNTERS_EN
    logic [31:0] retired_count_q;
    logic [31:0] redirect_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count_q  <= '0;
            redirect_count_q <= '0;
        end else if (retire_ok) begin
            retired_count_q <= retired_count_q + 32'd1;
            if (is_redirect && target_aligned) begin
                redirect_count_q <= redirect_count_q + 32'd1;
            end
        end
    end

    assign retired_count_o  = retired_count_q;
    assign redirect_count_o = redirect_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  pc_source;
    logic [31:0] branch_offset;
    logic [31:0] alu_result;
    logic        retire;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        misaligned;
    logic [31:0] misaligned_addr;
`ifdef PC_FETCH_COUNTERS_EN
    logic [31:0] retired_count;
    logic [31:0] redirect_count;
`endif

    pc_fetch_unit_if #(.XLEN(32)) mi ();

    pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_source_i       (pc_source),
        .branch_offset_i   (branch_offset),
        .alu_result_i      (alu_result),
        .retire_i          (retire),
        .stall_i           (stall),
        .imem              (mi),
        .inst_o            (inst),
        .inst_pc_o         (inst_pc),
        .inst_valid_o      (inst_valid),
        .misaligned_o      (misaligned),
        .misaligned_addr_o (misaligned_addr)
`ifdef PC_FETCH_COUNTERS_EN
        ,
        .retired_count_o   (retired_count),
        .redirect_count_o  (redirect_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    int resp_delay = 1;
    bit stray_data = 1'b0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] off;
        logic [31:0] alu;
        logic [31:0] exp;
        bit          trap;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) seen = 1'b1;
        end
        check({name, "_valid_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mi.imem_req === 1'b1) seen = 1'b1;
        end
        if (seen) check({name, "_addr"}, mi.imem_addr, exp_addr);
        else      check({name, "_req_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset         = 1'b1;
        retire        = 1'b0;
        stall         = 1'b0;
        mi.imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
    endtask

    // Memory model: one response resp_delay cycles after each handshake.
    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        mi.imem_rvalid = 1'b0;
        mi.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mi.imem_req === 1'b1 && mi.imem_ready === 1'b1) begin
                ra = mi.imem_addr;
                rd = stray_data ? 32'hDEAD_BEEF : (ra ^ 32'h1357_9BDF);
                sb_q.push_back('{ra, rd});
                repeat (resp_delay) @(posedge clk);
                #1;
                mi.imem_rvalid = 1'b1;
                mi.imem_rdata  = rd;
                @(posedge clk);
                #1;
                mi.imem_rvalid = 1'b0;
                mi.imem_rdata  = $urandom;
            end
        end
    end

    // Scoreboard: each newly presented instruction must match the oldest fetch.
    initial begin
        bit  prev;
        sb_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (inst_valid === 1'b1 && !prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: inst_valid rose with inst_pc=%h but no fetch pending", inst_pc);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_inst_pc", inst_pc, e.addr);
                    check("sb_inst", inst, e.data);
                end
            end
            prev = (inst_valid === 1'b1);
        end
    end

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] inst0;
        logic [31:0] pc0;
        bit          ok;
        int          exp_retired;
        int          exp_redirect;

        tbl[0]  = '{2'd0, 32'h0,         32'h0,         32'h0000_0004, 1'b0};
        tbl[1]  = '{2'd0, 32'h0,         32'h0,         32'h0000_0008, 1'b0};
        tbl[2]  = '{2'd0, 32'h0,         32'h0,         32'h0000_000C, 1'b0};
        tbl[3]  = '{2'd2, 32'h0,         32'h0000_0101, 32'h0000_0100, 1'b0};
        tbl[4]  = '{2'd1, 32'hFFFF_FFF0, 32'h0,         32'h0000_00F0, 1'b0};
        tbl[5]  = '{2'd3, 32'h0000_0040, 32'h0000_0777, 32'h0000_00F4, 1'b0};
        tbl[6]  = '{2'd1, 32'hFFFF_FF2C, 32'h0,         32'h0000_0020, 1'b0};
        tbl[7]  = '{2'd2, 32'h0,         32'h0000_0301, 32'h0000_0300, 1'b0};
        tbl[8]  = '{2'd2, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
        tbl[9]  = '{2'd0, 32'h0,         32'h0,         32'h0000_0000, 1'b0};
        tbl[10] = '{2'd1, 32'h0000_0020, 32'h0,         32'h0000_0020, 1'b0};
        tbl[11] = '{2'd2, 32'h0,         32'h0000_0302, 32'h0000_0302, 1'b1};

        reset         = 1'b1;
        retire        = 1'b0;
        stall         = 1'b0;
        pc_source     = 2'd0;
        branch_offset = '0;
        alu_result    = '0;
        mi.imem_ready = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_misaligned_addr", misaligned_addr, 32'd0);
        check("rst_imem_addr", mi.imem_addr, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("req_after_reset", {31'd0, mi.imem_req}, 32'd1);

        // Stall in FETCH, then stalled retire in ISSUE.
        @(posedge clk);
        #1;
        stall         = 1'b1;
        mi.imem_ready = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (mi.imem_req !== 1'b0) ok = 1'b0;
        end
        check("stall_fetch_no_req", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        stall = 1'b0;
        wait_valid("stall_first");
        check("stall_first_pc", inst_pc, 32'd0);
        inst0 = inst;
        pc0   = inst_pc;
        @(posedge clk);
        #1;
        stall     = 1'b1;
        retire    = 1'b1;
        pc_source = 2'd0;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (inst_valid !== 1'b1 || inst !== inst0 || inst_pc !== pc0 || mi.imem_req !== 1'b0) ok = 1'b0;
        end
        check("stall_issue_hold", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        stall = 1'b0;
        @(posedge clk);
        #1;
        retire = 1'b0;
        wait_req("stall_release", 32'h0000_0004);

        // Reset during WAIT, stray response afterwards.
        do_reset();
        resp_delay    = 3;
        stray_data    = 1'b1;
        mi.imem_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (mi.imem_req === 1'b1) ok = 1'b1;
        end
        check("stray_handshake", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        stall         = 1'b1;
        mi.imem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (inst_valid !== 1'b0) ok = 1'b0;
        end
        check("stray_ignored", {31'd0, ok}, 32'd1);
        check("stray_pc_reset", mi.imem_addr, 32'h0000_0000);
        resp_delay = 1;
        stray_data = 1'b0;
        @(posedge clk);
        #1;
        stall         = 1'b0;
        mi.imem_ready = 1'b1;
        wait_req("stray_refetch", 32'h0000_0000);
        wait_valid("stray_refetch");
        check("stray_refetch_inst", inst, 32'h1357_9BDF);

        // Table-driven next-PC sequence ending in a misaligned trap.
        do_reset();
        mi.imem_ready = 1'b1;
        cur_pc        = 32'h0;
        exp_retired   = 0;
        exp_redirect  = 0;
        for (int v = 0; v < 12; v++) begin
            wait_valid($sformatf("vec%0d", v));
            check($sformatf("vec%0d_inst_pc", v), inst_pc, cur_pc);
            @(posedge clk);
            #1;
            retire        = 1'b1;
            pc_source     = tbl[v].src;
            branch_offset = tbl[v].off;
            alu_result    = tbl[v].alu;
            @(posedge clk);
            #1;
            retire = 1'b0;
            exp_retired++;
            if ((tbl[v].src == 2'd1 || tbl[v].src == 2'd2) && !tbl[v].trap) exp_redirect++;
            if (!tbl[v].trap) begin
                wait_req($sformatf("vec%0d", v), tbl[v].exp);
                cur_pc = tbl[v].exp;
            end else begin
                @(negedge clk);
                check("trap_misaligned", {31'd0, misaligned}, 32'd1);
                check("trap_addr", misaligned_addr, tbl[v].exp);
                retire = 1'b1;
                ok = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    if (mi.imem_req !== 1'b0 || inst_valid !== 1'b0 || misaligned !== 1'b1) ok = 1'b0;
                end
                retire = 1'b0;
                check("trap_sticky", {31'd0, ok}, 32'd1);
            end
        end

`ifdef PC_FETCH_COUNTERS_EN
        check("retired_count", retired_count, exp_retired);
        check("redirect_count", redirect_count, exp_redirect);
`endif

        do_reset();
        @(negedge clk);
        check("post_trap_misaligned", {31'd0, misaligned}, 32'd0);
        check("post_trap_req", {31'd0, mi.imem_req}, 32'd1);
        check("post_trap_addr", mi.imem_addr, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
